acc_alu_unit: RTL

- Sequential ALU that sits directly downstream of the accumulator register.
- Operand A comes from the accumulator's dedicated ALU output. Operand B comes from the shared data bus.
- Single-cycle ops finish in one cycle. MUL is an iterative shift-add multiply.
- The registered result is driven back toward the bus for the accumulator to write on the next WR. A start/busy/done handshake coordinates with the control unit.

---
 rtl/acc_alu_pkg.sv | 22 ++
 rtl/acc_alu_unit_if.sv | 26 ++
 rtl/acc_mul_seq.sv | 43 ++++
 rtl/acc_alu_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/acc_alu_pkg.sv
// rtl/acc_alu_pkg.sv - shared opcodes, FSM encoding and default sizes for the accumulator ALU
package acc_alu_pkg;

   localparam int ACC_WIDTH = 16;
   localparam int ACC_CNT_W = 5;

   localparam logic [2:0] OP_CLR   = 3'b000;
   localparam logic [2:0] OP_PASSB = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_INC   = 3'b100;
   localparam logic [2:0] OP_MUL   = 3'b101;
   localparam logic [2:0] OP_SHL   = 3'b110;
   localparam logic [2:0] OP_SHR   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/acc_alu_unit_if.sv
// rtl/acc_alu_unit_if.sv - control/operand/result bundle between control unit and ALU
interface acc_alu_unit_if
   import acc_alu_pkg::*;
#(
   parameter int WIDTH = ACC_WIDTH
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] result;
   logic             z_flag;
   logic             c_flag;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a_in, b_in,
      input  result, z_flag, c_flag, busy, done
   );

   modport slave (
      input  start, op, a_in, b_in,
      output result, z_flag, c_flag, busy, done
   );
endinterface

// File: rtl/acc_mul_seq.sv
// rtl/acc_mul_seq.sv - iterative LSB-first shift-add multiplier, one multiplier bit per step
module acc_mul_seq
   import acc_alu_pkg::*;
#(
   parameter int WIDTH = ACC_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               step,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;

   // product already includes the step being taken this cycle, so the
   // controller can commit the final value on the last step's edge
   always_comb begin
      product = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   // operand latch on load, then shift multiplicand left / multiplier right per step
   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (load) begin
         mcand_q  <= {{WIDTH{1'b0}}, a};
         mplier_q <= b;
         acc_q    <= '0;
      end else if (step) begin
         acc_q    <= product;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end

endmodule

// File: rtl/acc_alu_unit.sv
// rtl/acc_alu_unit.sv - sequential ALU behind the accumulator with start/busy/done handshake
module acc_alu_unit
   import acc_alu_pkg::*;
#(
   parameter int WIDTH = ACC_WIDTH,
   parameter int CNT_W = ACC_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   acc_alu_unit_if.slave bus
);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   result_q;
   logic               z_q;
   logic               c_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic [WIDTH:0]     sum_ext;
   logic               accept;
   logic               mul_load;
   logic               mul_step;
   logic [2*WIDTH-1:0] mul_product;
   logic               mul_last;

   assign bus.result = result_q;
   assign bus.z_flag = z_q;
   assign bus.c_flag = c_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

   assign accept   = (state_q == ST_IDLE || state_q == ST_DONE) && bus.start;
   assign mul_load = !rst && accept && (bus.op == OP_MUL);
   assign mul_step = (state_q == ST_MUL);
   assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));

   acc_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .load    (mul_load),
      .a       (bus.a_in),
      .b       (bus.b_in),
      .step    (mul_step),
      .product (mul_product)
   );

   // single-cycle datapath; MUL is handled by the iterative unit
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      sum_ext = '0;
      case (bus.op)
         OP_CLR: begin
            alu_res = '0;
            alu_c   = 1'b0;
         end
         OP_PASSB: begin
            alu_res = bus.b_in;
            alu_c   = 1'b0;
         end
         OP_ADD: begin
            sum_ext = {1'b0, bus.a_in} + {1'b0, bus.b_in};
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
         end
         OP_SUB: begin
            // the extra top bit of the widened difference is the unsigned borrow
            sum_ext = {1'b0, bus.a_in} - {1'b0, bus.b_in};
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
         end
         OP_INC: begin
            sum_ext = {1'b0, bus.a_in} + (WIDTH+1)'(1);
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
         end
         OP_SHL: begin
            alu_res = {bus.a_in[WIDTH-2:0], 1'b0};
            alu_c   = bus.a_in[WIDTH-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, bus.a_in[WIDTH-1:1]};
            alu_c   = bus.a_in[0];
         end
         default: begin
            alu_res = result_q;
            alu_c   = c_q;
         end
      endcase
   end

   // control FSM with registered result, flags, busy and done
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         result_q <= '0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  if (bus.op == OP_MUL) begin
                     cnt_q   <= '0;
                     state_q <= ST_MUL;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end else begin
                     result_q <= alu_res;
                     z_q      <= (alu_res == '0);
                     c_q      <= alu_c;
                     state_q  <= ST_DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                  end
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b0;
               end
            end
            ST_MUL: begin
               // start is deliberately ignored here; the operation runs to completion
               cnt_q <= cnt_q + CNT_W'(1);
               if (mul_last) begin
                  result_q <= mul_product[WIDTH-1:0];
                  z_q      <= (mul_product[WIDTH-1:0] == '0);
                  c_q      <= |mul_product[2*WIDTH-1:WIDTH];
                  state_q  <= ST_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
